// File: rtl/tdm_pkg.sv
// tdm_pkg: shared definitions for the 4-slot TDM channel-select path.
//   SLOTS      - slots per frame (one per channel)
//   SLOT_W     - width of a slot index
//   state_t    - receive framer state (HUNT / LOCKED)
//   slot_idx_t - slot index type, shared with the serialising mux side
package tdm_pkg;

  localparam int SLOTS  = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef logic [SLOT_W-1:0] slot_idx_t;

endpackage : tdm_pkg

// File: rtl/tdm_demux4.sv
// tdm_demux4: receive side of the 4:1 channel-select path.
// Takes a serial stream of 4-slot frames (slot n carries channel n), buffers
// a frame in shadow registers and updates all four lanes together on the
// beat that completes the frame.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   in_valid    slot beat present on in_data this cycle
//   in_sof      start of frame (slot 0), qualified by in_valid
//   in_data     slot payload
//   out0..out3  per-channel lanes, frame-aligned and held
//   frame_valid one-cycle pulse: lanes were just updated
//   locked      high while aligned to frame boundaries
//   sync_err    one-cycle pulse on a framing violation
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic              frame_valid,
  output logic              locked,
  output logic              sync_err
);

  localparam slot_idx_t LAST_SLOT = slot_idx_t'(SLOTS - 1);

  state_t            state_reg;
  slot_idx_t         slot_cnt_reg;
  logic [DATA_W-1:0] shadow_reg [SLOTS];
  logic [DATA_W-1:0] lane_reg   [SLOTS];
  logic              frame_valid_reg;
  logic              sync_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= HUNT;
      slot_cnt_reg    <= '0;
      frame_valid_reg <= 1'b0;
      sync_err_reg    <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        shadow_reg[i] <= '0;
        lane_reg[i]   <= '0;
      end
    end else begin
      // Pulses last exactly one cycle; a stall cycle clears them too.
      frame_valid_reg <= 1'b0;
      sync_err_reg    <= 1'b0;

      if (in_valid) begin
        case (state_reg)
          HUNT: begin
            // Non-SOF beats are dropped silently while hunting.
            if (in_sof) begin
              shadow_reg[0] <= in_data;
              slot_cnt_reg  <= slot_idx_t'(1);
              state_reg     <= LOCKED;
            end
          end

          LOCKED: begin
            if (in_sof) begin
              // An SOF mid-frame restarts the frame on this beat; the
              // stale shadow slots are overwritten before they are used.
              if (slot_cnt_reg != '0) begin
                sync_err_reg <= 1'b1;
              end
              shadow_reg[0] <= in_data;
              slot_cnt_reg  <= slot_idx_t'(1);
            end else if (slot_cnt_reg == '0) begin
              // Expected an SOF here: alignment lost.
              sync_err_reg <= 1'b1;
              state_reg    <= HUNT;
            end else if (slot_cnt_reg == LAST_SLOT) begin
              // Slot 3 goes straight to its lane so all four update on
              // the same edge without a bubble before the next frame.
              for (int i = 0; i < SLOTS - 1; i++) begin
                lane_reg[i] <= shadow_reg[i];
              end
              lane_reg[SLOTS-1] <= in_data;
              frame_valid_reg   <= 1'b1;
              slot_cnt_reg      <= '0;
            end else begin
              shadow_reg[slot_cnt_reg] <= in_data;
              slot_cnt_reg             <= slot_cnt_reg + 1'b1;
            end
          end

          default: begin
            state_reg <= HUNT;
          end
        endcase
      end
    end
  end

  assign out0        = lane_reg[0];
  assign out1        = lane_reg[1];
  assign out2        = lane_reg[2];
  assign out3        = lane_reg[3];
  assign frame_valid = frame_valid_reg;
  assign sync_err    = sync_err_reg;
  assign locked      = (state_reg == LOCKED);

endmodule : tdm_demux4

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: self-checking bench for tdm_demux4 with a queue-based
// reference model of the framing rules.
module tb_tdm_demux4;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] in_data;
  logic [DW-1:0] out0, out1, out2, out3;
  logic          frame_valid, locked, sync_err;

  always #5 clk = ~clk;

  tdm_demux4 #(.DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_data     (in_data),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_frames = 0;

  // Reference model: the beats gathered for the frame in progress are kept
  // in a queue; a frame is published when the queue reaches four entries.
  bit            m_locked;
  logic [DW-1:0] m_part[$];
  logic [DW-1:0] m_lanes[4];
  bit            m_fv;
  bit            m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_beat(input bit r, input bit v, input bit s, input logic [DW-1:0] d);
    m_fv  = 0;
    m_err = 0;
    if (r) begin
      m_locked = 0;
      m_part.delete();
      for (int i = 0; i < 4; i++) m_lanes[i] = '0;
    end else if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_locked = 1;
          m_part.delete();
          m_part.push_back(d);
        end
      end else if (s) begin
        if (m_part.size() != 0) m_err = 1;
        m_part.delete();
        m_part.push_back(d);
      end else if (m_part.size() == 0) begin
        m_err    = 1;
        m_locked = 0;
      end else begin
        m_part.push_back(d);
        if (m_part.size() == 4) begin
          for (int i = 0; i < 4; i++) m_lanes[i] = m_part[i];
          m_part.delete();
          m_fv = 1;
        end
      end
    end
  endtask

  // One clock cycle: drive on the falling edge, sample 1 ns after rising.
  task automatic step(input bit v, input bit s, input logic [DW-1:0] d, input bit r);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge clk);
    model_beat(r, v, s, d);
    #1;
    check("out0", out0, m_lanes[0]);
    check("out1", out1, m_lanes[1]);
    check("out2", out2, m_lanes[2]);
    check("out3", out3, m_lanes[3]);
    check("frame_valid", frame_valid, m_fv);
    check("sync_err", sync_err, m_err);
    check("locked", locked, m_locked);
    if (m_fv) begin
      n_frames++;
      $display("frame %0d: lanes %h %h %h %h", n_frames, m_lanes[0], m_lanes[1], m_lanes[2], m_lanes[3]);
    end
  endtask

  task automatic beat(input bit s, input logic [DW-1:0] d);
    step(1'b1, s, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
  endtask

  int gen_pos;
  bit rv, rs, rr;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    m_locked = 0;
    for (int i = 0; i < 4; i++) m_lanes[i] = '0;

    // Reset state.
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 4'h5, 1'b1);
    check("reset_lanes", {out3, out2, out1, out0}, 16'h0000);
    idle(1);

    // Basic frame 1,0,1,0.
    beat(1'b1, 4'h1);
    check("lock_after_sof", locked, 1'b1);
    beat(1'b0, 4'h0);
    beat(1'b0, 4'h1);
    beat(1'b0, 4'h0);
    check("frame1_lanes", {out3, out2, out1, out0}, 16'h0101);
    check("frame1_fv", frame_valid, 1'b1);
    idle(1);
    check("frame1_fv_one_cycle", frame_valid, 1'b0);

    // Same frame with a 2-cycle stall between slots 1 and 2.
    beat(1'b1, 4'h1);
    beat(1'b0, 4'h0);
    idle(2);
    beat(1'b0, 4'h1);
    beat(1'b0, 4'h0);

    // Back-to-back frames.
    beat(1'b1, 4'h1); beat(1'b0, 4'h0); beat(1'b0, 4'h1); beat(1'b0, 4'h0);
    beat(1'b1, 4'h0); beat(1'b0, 4'h1); beat(1'b0, 4'h1); beat(1'b0, 4'h1);
    check("b2b_lanes", {out3, out2, out1, out0}, 16'h1110);

    // Early SOF.
    beat(1'b1, 4'h1); beat(1'b0, 4'h0);
    beat(1'b1, 4'h0);
    check("early_sof_err", sync_err, 1'b1);
    beat(1'b0, 4'h1); beat(1'b0, 4'h1); beat(1'b0, 4'h0);
    check("early_sof_lanes", {out3, out2, out1, out0}, 16'h0110);

    // Missing SOF after a completed frame.
    beat(1'b0, 4'h7);
    check("missing_sof_err", sync_err, 1'b1);
    check("missing_sof_unlock", locked, 1'b0);
    beat(1'b0, 4'h3); beat(1'b0, 4'h2); beat(1'b0, 4'h1); beat(1'b0, 4'h9);
    check("hunt_hold_lanes", {out3, out2, out1, out0}, 16'h0110);

    // Reset after slot 2, then a full frame.
    beat(1'b1, 4'hA); beat(1'b0, 4'hB); beat(1'b0, 4'hC);
    step(1'b0, 1'b0, '0, 1'b1);
    check("midreset_lanes", {out3, out2, out1, out0}, 16'h0000);
    beat(1'b1, 4'h4); beat(1'b0, 4'h3); beat(1'b0, 4'h2); beat(1'b0, 4'h1);
    check("post_reset_lanes", {out3, out2, out1, out0}, 16'h1234);

    // Randomized traffic: mostly well-formed frames with stalls, with
    // occasional flipped SOF flags and rare resets.
    gen_pos = 0;
    for (int n = 0; n < 3000; n++) begin
      rv = ($urandom_range(0, 3) != 0);
      rs = (gen_pos == 0);
      if ($urandom_range(0, 19) == 0) rs = !rs;
      rr = ($urandom_range(0, 199) == 0);
      step(rv, rs, DW'($urandom), rr);
      if (rr) gen_pos = 0;
      else if (rv) gen_pos = rs ? 1 : (gen_pos + 1) % 4;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_tdm_demux4
